// File: rtl/apb_uart_pkg.sv
// Shared constants and types for the APB UART register front-end.
// Register offsets, CTRL/STATUS bit positions, byte type.
package apb_uart_pkg;

  localparam logic [11:0] ADDR_DATA   = 12'h000;
  localparam logic [11:0] ADDR_STATUS = 12'h004;
  localparam logic [11:0] ADDR_CTRL   = 12'h008;
  localparam logic [11:0] ADDR_BAUD   = 12'h00C;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_PAR   = 1;
  localparam int CTRL_ODD   = 2;
  localparam int CTRL_TXFL  = 3;
  localparam int CTRL_RXFL  = 4;
  localparam int CTRL_TXIE  = 5;
  localparam int CTRL_RXIE  = 6;

  localparam int ST_TXE   = 0;
  localparam int ST_TXF   = 1;
  localparam int ST_RXE   = 2;
  localparam int ST_RXF   = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_TXLVL = 8;
  localparam int ST_RXLVL = 12;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/apb_uart_fifo.sv
// Byte FIFO with push/pop/flush; fullness and emptiness are
// pre-edge, so a same-cycle pop never makes room for a push.
module apb_uart_fifo
  import apb_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  uart_byte_t data_i,
  output uart_byte_t data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [3:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  uart_byte_t     mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [3:0]     cnt_q;
  logic           push_ok;
  logic           pop_ok;

  assign full_o  = (cnt_q == 4'(DEPTH));
  assign empty_o = (cnt_q == 4'd0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + 4'(push_ok) - 4'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/apb_uart_csr.sv
// APB register front-end for the UART: DATA/STATUS/CTRL/BAUD.
// APB_UART_IRQ_EN adds a registered irq output and CTRL[6:5].
module apb_uart_csr
  import apb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RST   = 16'd54
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        uart_en,
  output logic        parity_en,
  output logic        parity_odd,
  output logic [15:0] baud_div
`ifdef APB_UART_IRQ_EN
  ,
  output logic        irq
`endif
);

`ifdef APB_UART_IRQ_EN
  localparam logic [6:0] CTRL_WMASK = 7'h67;
`else
  localparam logic [6:0] CTRL_WMASK = 7'h07;
`endif

  logic [6:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  logic        ovf_q, ovf_d;
  logic        ovf_clr, ovf_set;

  logic        access, addr_ok;
  logic [11:0] off;
  logic        sel_data, sel_stat, sel_ctrl, sel_baud;
  logic [31:0] status;

  logic        tx_push, tx_pop, tx_flush;
  logic        rx_push, rx_pop, rx_flush;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [3:0]  tx_level, rx_level;
  uart_byte_t  tx_head, rx_head;

  logic        unused_bits;
  assign unused_bits = ^{paddr[31:12], pwdata[31:16]};

  // a transfer caught by reset is neither completed nor decoded
  assign access  = psel & penable & presetn;
  assign off     = paddr[11:0];
  assign addr_ok = (off[1:0] == 2'b00) && (off <= ADDR_BAUD);
  assign sel_data = addr_ok && (off == ADDR_DATA);
  assign sel_stat = addr_ok && (off == ADDR_STATUS);
  assign sel_ctrl = addr_ok && (off == ADDR_CTRL);
  assign sel_baud = addr_ok && (off == ADDR_BAUD);

  assign pready     = access;
  assign uart_en    = ctrl_q[CTRL_EN];
  assign parity_en  = ctrl_q[CTRL_PAR];
  assign parity_odd = ctrl_q[CTRL_ODD];
  assign baud_div   = baud_q;
  assign tx_data    = tx_head;
  assign tx_valid   = uart_en & ~tx_empty;
  assign tx_pop     = tx_valid & tx_ready;
  assign rx_push    = rx_valid & uart_en;
  assign ovf_set    = rx_push & rx_full & ~rx_flush;

  always_comb begin
    status           = '0;
    status[ST_TXE]   = tx_empty;
    status[ST_TXF]   = tx_full;
    status[ST_RXE]   = rx_empty;
    status[ST_RXF]   = rx_full;
    status[ST_OVF]   = ovf_q;
    status[ST_TXLVL +: 4] = tx_level;
    status[ST_RXLVL +: 4] = rx_level;
  end

  always_comb begin
    prdata   = '0;
    pslverr  = 1'b0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    tx_flush = 1'b0;
    rx_flush = 1'b0;
    ovf_clr  = 1'b0;
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    if (access) begin
      unique case (1'b1)
        !addr_ok: pslverr = 1'b1;
        sel_data: begin
          if (pwrite) begin
            if (tx_full) pslverr = 1'b1;
            else         tx_push = 1'b1;
          end else if (rx_empty) begin
            pslverr = 1'b1;
          end else begin
            prdata = {24'b0, rx_head};
            rx_pop = 1'b1;
          end
        end
        sel_stat: begin
          if (pwrite) ovf_clr = pwdata[ST_OVF];
          else        prdata  = status;
        end
        sel_ctrl: begin
          if (pwrite) begin
            ctrl_d   = pwdata[6:0] & CTRL_WMASK;
            tx_flush = pwdata[CTRL_TXFL];
            rx_flush = pwdata[CTRL_RXFL];
          end else begin
            prdata = {25'b0, ctrl_q};
          end
        end
        sel_baud: begin
          if (pwrite) begin
            if (pwdata[15:0] == 16'd0) pslverr = 1'b1;
            else                       baud_d  = pwdata[15:0];
          end else begin
            prdata = {16'b0, baud_q};
          end
        end
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ctrl_q <= '0;
      baud_q <= BAUD_RST;
      ovf_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      baud_q <= baud_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef APB_UART_IRQ_EN
  logic irq_q;
  assign irq = irq_q;
  always_ff @(posedge pclk) begin
    if (!presetn) irq_q <= 1'b0;
    else irq_q <= (ctrl_q[CTRL_TXIE] & tx_empty)
                | (ctrl_q[CTRL_RXIE] & (~rx_empty | ovf_q));
  end
`endif

  apb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .data_i  (pwdata[7:0]),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  apb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .data_i  (rx_data),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

endmodule

// File: tb/tb_apb_uart_csr.sv
// Bench for apb_uart_csr: APB transfers, TX/RX streams, reset.
// Expected APB responses and stream bytes flow through queues.
module tb_apb_uart_csr;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        uart_en;
  logic        parity_en;
  logic        parity_odd;
  logic [15:0] baud_div;
`ifdef APB_UART_IRQ_EN
  logic        irq;
  localparam logic [31:0] CTRL_EXP = 32'h67;
`else
  localparam logic [31:0] CTRL_EXP = 32'h07;
`endif

  apb_uart_csr dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .uart_en    (uart_en),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .baud_div   (baud_div)
`ifdef APB_UART_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         n_run = 0;
  int         n_fail = 0;
  logic [31:0] rd;
  logic        er;
  logic        rdy;
  exp_t        ex;

  // one APB transfer; response sampled mid-way through access
  task automatic apb(input logic [31:0] a, input logic w,
                     input logic [31:0] wd, output logic [31:0] d,
                     output logic e, output logic r);
    @(negedge pclk);
    paddr = a; pwrite = w; pwdata = wd;
    psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d = prdata; e = pslverr; r = pready;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge pclk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge pclk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ad [2];
    ad = '{32'h4, 32'hC};
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    n_run++;
    if ({tx_valid, pready, pslverr, prdata} !== 35'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b%b%b %h, want 000 0",
               tx_valid, pready, pslverr, prdata);
    end
    exp_q.push_back('{32'h5, 1'b0});
    exp_q.push_back('{32'h36, 1'b0});
    for (int i = 0; i < 2; i++) begin
      apb(ad[i], 1'b0, 32'h0, rd, er, rdy);
      ex = exp_q.pop_front();
      n_run++;
      if (rd !== ex.d || er !== ex.e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_rd[%0d]: got %h/%b/%b, want %h/%b/1",
                 i, rd, er, rdy, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_tx_stream();
    logic [7:0] b [2];
    b = '{8'hA5, 8'h3C};
    tx_ready = 1'b0;
    apb(32'h8, 1'b1, 32'h1, rd, er, rdy);
    n_run++;
    if (uart_en !== 1'b1 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_en: got en=%b err=%b, want 1/0", uart_en, er);
    end
    for (int i = 0; i < 2; i++) begin
      tx_q.push_back(b[i]);
      exp_q.push_back('{32'h0, 1'b0});
      apb(32'h0, 1'b1, {24'h0, b[i]}, rd, er, rdy);
      ex = exp_q.pop_front();
      n_run++;
      if (rd !== ex.d || er !== ex.e) begin
        n_fail++;
        $display("FAIL tx_wr[%0d]: got %h/%b, want %h/%b",
                 i, rd, er, ex.d, ex.e);
      end
    end
    exp_q.push_back('{32'h0204, 1'b0});
    apb(32'h4, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL tx_status: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      n_run++;
      if (tx_valid !== 1'b1 || tx_data !== tx_q.pop_front()) begin
        n_fail++;
        $display("FAIL tx_pop[%0d]: got v=%b d=%h", c, tx_valid, tx_data);
      end
      @(negedge pclk);
    end
    n_run++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_drained: got valid=%b, want 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_full();
    logic [7:0] b;
    logic [7:0] h;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      if (tx_q.size() < 8) begin
        tx_q.push_back(b);
        exp_q.push_back('{32'h0, 1'b0});
      end else begin
        exp_q.push_back('{32'h0, 1'b1});
      end
      apb(32'h0, 1'b1, {24'h0, b}, rd, er, rdy);
      ex = exp_q.pop_front();
      n_run++;
      if (rd !== ex.d || er !== ex.e) begin
        n_fail++;
        $display("FAIL tx_fill[%0d]: got %h/%b, want %h/%b",
                 i, rd, er, ex.d, ex.e);
      end
    end
    exp_q.push_back('{32'h0806, 1'b0});
    apb(32'h4, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL tx_full_st: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
    h = tx_q[0];
    repeat (3) @(negedge pclk);
    n_run++;
    if (tx_valid !== 1'b1 || tx_data !== h) begin
      n_fail++;
      $display("FAIL tx_hold: got v=%b d=%h, want 1 %h", tx_valid, tx_data, h);
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 20 && tx_valid === 1'b1; c++) begin
      n_run++;
      if (tx_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_extra: got byte %h, want none", tx_data);
      end else if (tx_data !== tx_q.pop_front()) begin
        n_fail++;
        $display("FAIL tx_order[%0d]: got %h", c, tx_data);
      end
      @(negedge pclk);
    end
    n_run++;
    if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_drain: got left=%0d v=%b, want 0 0",
               tx_q.size(), tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic ovf_m;
    ovf_m = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (rx_q.size() < 8) rx_q.push_back(8'(i));
      else                 ovf_m = 1'b1;
      rx_pulse(8'(i));
    end
    exp_q.push_back('{32'h8009 | {27'h0, ovf_m, 4'h0} | 32'h10 & 32'h0, 1'b0});
    exp_q[$].d = 32'h8009 | (ovf_m ? 32'h10 : 32'h0);
    apb(32'h4, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL rx_ovf_st: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
    for (int i = 0; i < 9; i++) begin
      if (rx_q.size() > 0) exp_q.push_back('{{24'h0, rx_q.pop_front()}, 1'b0});
      else                 exp_q.push_back('{32'h0, 1'b1});
      apb(32'h0, 1'b0, 32'h0, rd, er, rdy);
      ex = exp_q.pop_front();
      n_run++;
      if (rd !== ex.d || er !== ex.e) begin
        n_fail++;
        $display("FAIL rx_rd[%0d]: got %h/%b, want %h/%b",
                 i, rd, er, ex.d, ex.e);
      end
    end
    apb(32'h4, 1'b1, 32'h10, rd, er, rdy);
    exp_q.push_back('{32'h5, 1'b0});
    apb(32'h4, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL rx_w1c: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
    apb(32'h8, 1'b1, 32'h0, rd, er, rdy);
    rx_pulse(8'h55);
    exp_q.push_back('{32'h5, 1'b0});
    apb(32'h4, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL rx_disabled: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
  endtask

  task automatic test_regs_flush();
    logic [31:0] ad [16];
    logic        wr [16];
    logic [31:0] wd [16];
    logic [31:0] ed [16];
    logic        ee [16];
    ad = '{32'h8, 32'h8, 32'h6, 32'h10, 32'h2, 32'hFFC, 32'h8, 32'hC,
           32'hC, 32'hC, 32'hC, 32'h8, 32'h0, 32'h0, 32'h8, 32'h4};
    wr = '{1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0};
    wd = '{32'h67, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0,
           32'h1, 32'h11, 32'h22, 32'h9, 0};
    ed = '{0, CTRL_EXP, 0, 0, 0, 0, CTRL_EXP, 0, 32'h36, 0, 32'h1234,
           0, 0, 0, 0, 32'h5};
    ee = '{0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{ed[i], ee[i]});
      apb(ad[i], wr[i], wd[i], rd, er, rdy);
      ex = exp_q.pop_front();
      n_run++;
      if (rd !== ex.d || er !== ex.e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL regs[%0d]: got %h/%b/%b, want %h/%b/1",
                 i, rd, er, rdy, ex.d, ex.e);
      end
    end
    n_run++;
    if (baud_div !== 16'h1234 || uart_en !== 1'b1) begin
      n_fail++;
      $display("FAIL regs_out: got baud=%h en=%b, want 1234 1",
               baud_div, uart_en);
    end
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    apb(32'h8, 1'b1, 32'h11, rd, er, rdy);
    exp_q.push_back('{32'h5, 1'b0});
    exp_q.push_back('{32'h1, 1'b0});
    apb(32'h4, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL rx_flush: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
    apb(32'h8, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL ctrl_rd: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) apb(32'h0, 1'b1, 32'(i + 7), rd, er, rdy);
    @(negedge pclk);
    paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hEE;
    psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    presetn = 1'b0;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    n_run++;
    if ({pready, pslverr, tx_valid, uart_en} !== 4'b0 ||
        baud_div !== 16'h36) begin
      n_fail++;
      $display("FAIL mid_rst_out: got %b%b%b%b baud=%h, want 0000 0036",
               pready, pslverr, tx_valid, uart_en, baud_div);
    end
    exp_q.push_back('{32'h5, 1'b0});
    exp_q.push_back('{32'h0, 1'b0});
    apb(32'h4, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL mid_rst_st: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
    apb(32'h8, 1'b0, 32'h0, rd, er, rdy);
    ex = exp_q.pop_front();
    n_run++;
    if (rd !== ex.d || er !== ex.e) begin
      n_fail++;
      $display("FAIL mid_rst_ctrl: got %h/%b, want %h/%b", rd, er, ex.d, ex.e);
    end
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_tx_full();
    test_rx_overflow();
    test_regs_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
